// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// The optional starvation guard is enabled with the macro DMEM_ARB_STARVE_GUARD_EN.
package dmem_arb_pkg;

    // Default geometry of the request ports and the starvation threshold.
    localparam int DMEM_ADDR_W       = 32;
    localparam int DMEM_DATA_W       = 32;
    localparam int DMEM_STARVE_LIMIT = 8;

    // Arbiter operating mode.
    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        DRAIN  = 2'd1,
        LOAD   = 2'd2
    } arb_state_e;

    // Which port owns the read response currently in flight.
    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_UART = 1'b1
    } owner_e;

    // Bits needed to count from 0 up to and including limit.
    function automatic int cnt_width(input int limit);
        int w;
        w = 1;
        if (limit > 1) begin
            w = $clog2(limit + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Counts consecutive cycles in which the UART loader asks for the memory and is
// refused. Saturates at LIMIT; at_limit_o tells the arbiter to hand the next
// cycle to the loader. Only instantiated when DMEM_ARB_STARVE_GUARD_EN is defined.
module starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int LIMIT = DMEM_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic gnt_i,
    output logic at_limit_o
);

    localparam int             CNT_W   = cnt_width(LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: grow while refused, hold at the limit, drop to zero otherwise.
    always_comb begin
        cnt_d = '0;
        if (req_i && !gnt_i) begin
            if (cnt_q == LIMIT_C) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter register, cleared by the active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: a CPU port and a UART loader port share one
// single-access-per-cycle memory. Grants are combinational in the request
// cycle; read data returns one cycle later and is steered by a registered owner
// tag. The loader can take exclusive ownership (LOAD) via uart_lock, passing
// through DRAIN when a read is still in flight.
// Optional feature: define DMEM_ARB_STARVE_GUARD_EN to add loader starvation
// forcing; without it NORMAL mode is strictly CPU-first.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
    input  logic                clk,
    input  logic                reset,

    // CPU request / response
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wmask,
    output logic                cpu_gnt,
    output logic                cpu_stall,
    output logic                cpu_rvalid,
    output logic [DATA_W-1:0]   cpu_rdata,

    // UART loader request / response
    input  logic                uart_req,
    input  logic                uart_we,
    input  logic [ADDR_W-1:0]   uart_addr,
    input  logic [DATA_W-1:0]   uart_wdata,
    input  logic [DATA_W/8-1:0] uart_wmask,
    output logic                uart_gnt,
    output logic                uart_rvalid,
    output logic [DATA_W-1:0]   uart_rdata,
    input  logic                uart_lock,
    output logic                lock_active,

    // Memory side
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_e state_q;
    logic       lock_active_q;

    logic       rd_pend_q;
    logic       rd_pend_d;
    owner_e     owner_q;
    owner_e     owner_d;

    logic       starve_force;
    logic       rd_accept;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic       starve_at_limit;

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clk        (clk),
        .reset      (reset),
        .req_i      (uart_req),
        .gnt_i      (uart_gnt),
        .at_limit_o (starve_at_limit)
    );

    assign starve_force = starve_at_limit;
`else
    // No guard: the loader never overrides the CPU in NORMAL. The limit term
    // only keeps the parameter referenced; the whole expression is constant 0.
    assign starve_force = 1'b0 & (STARVE_LIMIT == 0);
`endif

    // Grant selection for the current cycle, decided by mode and priority.
    always_comb begin
        cpu_gnt  = 1'b0;
        uart_gnt = 1'b0;
        case (state_q)
            NORMAL: begin
                if (uart_req && (starve_force || !cpu_req)) begin
                    uart_gnt = 1'b1;
                end else if (cpu_req) begin
                    cpu_gnt = 1'b1;
                end
            end
            LOAD: begin
                uart_gnt = uart_req;
            end
            default: begin
                // DRAIN: hold everyone off until the in-flight read lands.
                cpu_gnt  = 1'b0;
                uart_gnt = 1'b0;
            end
        endcase
    end

    // Memory command mux: the granted port's fields, zeros when idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wmask = cpu_wmask;
        end else if (uart_gnt) begin
            mem_we    = uart_we;
            mem_addr  = uart_addr;
            mem_wdata = uart_wdata;
            mem_wmask = uart_wmask;
        end
    end

    assign mem_en    = cpu_gnt | uart_gnt;
    assign rd_accept = mem_en & ~mem_we;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Next response tag: a read accepted now returns next cycle to its owner.
    always_comb begin
        rd_pend_d = rd_accept;
        owner_d   = owner_q;
        if (rd_accept) begin
            owner_d = uart_gnt ? OWN_UART : OWN_CPU;
        end
    end

    // Response tracking registers; reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_pend_q <= 1'b0;
            owner_q   <= OWN_CPU;
        end else begin
            rd_pend_q <= rd_pend_d;
            owner_q   <= owner_d;
        end
    end

    // Mode state machine with registered lock_active flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= NORMAL;
            lock_active_q <= 1'b0;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (uart_lock) begin
                        // A read granted in this very cycle still has to return.
                        if (rd_accept) begin
                            state_q       <= DRAIN;
                            lock_active_q <= 1'b0;
                        end else begin
                            state_q       <= LOAD;
                            lock_active_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Nothing is granted here, so the single in-flight read is
                    // delivered this cycle; leave on the following edge.
                    if (uart_lock) begin
                        state_q       <= LOAD;
                        lock_active_q <= 1'b1;
                    end else begin
                        state_q       <= NORMAL;
                        lock_active_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!uart_lock) begin
                        state_q       <= NORMAL;
                        lock_active_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= NORMAL;
                    lock_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign lock_active = lock_active_q;

    // Response steering: only the owner sees data, the other port reads zero.
    assign cpu_rvalid  = rd_pend_q && (owner_q == OWN_CPU);
    assign uart_rvalid = rd_pend_q && (owner_q == OWN_UART);
    assign cpu_rdata   = cpu_rvalid  ? mem_rdata : {DATA_W{1'b0}};
    assign uart_rdata  = uart_rvalid ? mem_rdata : {DATA_W{1'b0}};

    // MASK_W documents the byte-lane width shared by both ports.
    logic [MASK_W-1:0] unused_mask_w;
    assign unused_mask_w = mem_wmask;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model (mode, starvation count, in-flight read, memory image).
module tb_dmem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int MW    = DW / 8;
    localparam int LIMIT = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    localparam int S_NORMAL = 0;
    localparam int S_DRAIN  = 1;
    localparam int S_LOAD   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, uart_req, uart_we, uart_lock;
    logic [AW-1:0] cpu_addr, uart_addr;
    logic [DW-1:0] cpu_wdata, uart_wdata;
    logic [MW-1:0] cpu_wmask, uart_wmask;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, uart_gnt, uart_rvalid, lock_active;
    logic [DW-1:0] cpu_rdata, uart_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wmask(cpu_wmask), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
        .uart_wmask(uart_wmask), .uart_gnt(uart_gnt), .uart_rvalid(uart_rvalid),
        .uart_rdata(uart_rdata), .uart_lock(uart_lock), .lock_active(lock_active),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // Memory device: 16 words, registered read, byte-masked write.
    logic [31:0] ram [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[5:2]] <= merge(ram[mem_addr[5:2]], mem_wdata, mem_wmask);
            else        mem_rdata <= ram[mem_addr[5:2]];
        end
    end

    // Behavioural model state
    int          m_state;
    int          m_starve;
    bit          m_pend, m_pend_uart;
    logic [31:0] m_pend_data;
    logic [31:0] m_mem [16];

    int checks = 0;
    int errors = 0;

    // Samples of the last evaluated cycle, for the literal checks.
    logic        s_cpu_gnt, s_uart_gnt, s_cpu_stall, s_cpu_rvalid, s_uart_rvalid, s_lock, s_mem_en;
    logic [31:0] s_cpu_rdata;
    logic [3:0]  s_mem_wmask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Evaluate one clock cycle: compare DUT against the model, advance the model.
    task automatic step();
        bit          ec, eu, ewe, acc;
        logic [31:0] eaddr, ewd, erd_c, erd_u;
        logic [3:0]  emask;
        int          nstate;
        @(negedge clk);
        #1;
        ec = 1'b0;
        eu = 1'b0;
        if (m_state == S_NORMAL) begin
            if (uart_req && ((GUARD && m_starve == LIMIT) || !cpu_req)) eu = 1'b1;
            else if (cpu_req) ec = 1'b1;
        end else if (m_state == S_LOAD) begin
            eu = uart_req;
        end
        ewe   = ec ? cpu_we    : uart_we;
        eaddr = ec ? cpu_addr  : uart_addr;
        ewd   = ec ? cpu_wdata : uart_wdata;
        emask = ec ? cpu_wmask : uart_wmask;
        erd_c = (m_pend && !m_pend_uart) ? m_pend_data : 32'h0;
        erd_u = (m_pend &&  m_pend_uart) ? m_pend_data : 32'h0;

        chk("cpu_gnt", cpu_gnt, ec);
        chk("uart_gnt", uart_gnt, eu);
        chk("cpu_stall", cpu_stall, cpu_req && !ec);
        chk("mem_en", mem_en, ec || eu);
        chk("lock_active", lock_active, m_state == S_LOAD);
        chk("cpu_rvalid", cpu_rvalid, m_pend && !m_pend_uart);
        chk("uart_rvalid", uart_rvalid, m_pend && m_pend_uart);
        chk("cpu_rdata", cpu_rdata, erd_c);
        chk("uart_rdata", uart_rdata, erd_u);
        if (ec || eu) begin
            chk("mem_we", mem_we, ewe);
            chk("mem_addr", mem_addr, eaddr);
            chk("mem_wdata", mem_wdata, ewd);
            chk("mem_wmask", mem_wmask, emask);
        end

        s_cpu_gnt = cpu_gnt;  s_uart_gnt = uart_gnt;  s_cpu_stall = cpu_stall;
        s_cpu_rvalid = cpu_rvalid;  s_uart_rvalid = uart_rvalid;  s_lock = lock_active;
        s_mem_en = mem_en;  s_cpu_rdata = cpu_rdata;  s_mem_wmask = mem_wmask;

        // Advance the model to the next cycle.
        acc = (ec || eu) && !ewe;
        if ((ec || eu) && ewe) m_mem[eaddr[5:2]] = merge(m_mem[eaddr[5:2]], ewd, emask);
        m_pend      = acc;
        m_pend_uart = eu;
        m_pend_data = m_mem[eaddr[5:2]];
        nstate = m_state;
        if (m_state == S_NORMAL) begin
            if (uart_lock) nstate = acc ? S_DRAIN : S_LOAD;
        end else begin
            nstate = uart_lock ? S_LOAD : S_NORMAL;
        end
        m_state = nstate;
        if (uart_req && !eu) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
        else m_starve = 0;
        if (!reset) begin
            m_state  = S_NORMAL;
            m_starve = 0;
            m_pend   = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; uart_req = 1'b0; cpu_we = 1'b0; uart_we = 1'b0;
    endtask

    int first_gnt;

    initial begin
        reset = 1'b0; uart_lock = 1'b0;
        idle();
        cpu_addr = '0; uart_addr = '0; cpu_wdata = '0; uart_wdata = '0;
        cpu_wmask = '0; uart_wmask = '0; mem_rdata = '0;
        for (int i = 0; i < 16; i++) begin
            ram[i]   = 32'h1000_0000 + i * 32'h11;
            m_mem[i] = 32'h1000_0000 + i * 32'h11;
        end
        m_state = S_NORMAL; m_starve = 0; m_pend = 1'b0; m_pend_uart = 1'b0; m_pend_data = '0;
        @(posedge clk);
        #1;

        // Reset, then first idle cycle out of reset.
        step(); step();
        reset = 1'b1;
        step();
        chk("rst_cpu_gnt", s_cpu_gnt, 1'b0);
        chk("rst_mem_en", s_mem_en, 1'b0);
        chk("rst_lock", s_lock, 1'b0);
        chk("rst_rvalid", {s_cpu_rvalid, s_uart_rvalid}, 2'b00);

        // Both ports read 0x10 together: CPU wins, data next cycle.
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; uart_req = 1; uart_we = 0; uart_addr = 32'h10;
        step();
        chk("tie_cpu_gnt", s_cpu_gnt, 1'b1);
        chk("tie_uart_gnt", s_uart_gnt, 1'b0);
        idle();
        step();
        chk("tie_cpu_rvalid", s_cpu_rvalid, 1'b1);
        chk("tie_cpu_rdata", s_cpu_rdata, 32'h1000_0044);

        // Continuous CPU traffic against a waiting UART read of 0x20.
        first_gnt = 0;
        for (int i = 1; i <= 12; i++) begin
            cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0; uart_req = 1; uart_we = 0; uart_addr = 32'h20;
            step();
            if (s_uart_gnt && first_gnt == 0) first_gnt = i;
        end
        chk("starve_first_uart_gnt", first_gnt, GUARD ? 32'd9 : 32'd0);
        idle();
        step(); step();

        // CPU read of 0x04 with uart_lock rising in the same cycle.
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h04; uart_lock = 1;
        step();
        chk("lock_cpu_gnt", s_cpu_gnt, 1'b1);
        cpu_req = 0; uart_req = 1; uart_we = 0; uart_addr = 32'h8;
        step();
        chk("drain_lock_low", s_lock, 1'b0);
        chk("drain_no_uart_gnt", s_uart_gnt, 1'b0);
        chk("drain_cpu_rvalid", s_cpu_rvalid, 1'b1);
        chk("drain_cpu_rdata", s_cpu_rdata, 32'h1000_0011);

        // LOAD: loader writes 0xDEADBEEF to 0x0 while the CPU is stalled.
        uart_req = 1; uart_we = 1; uart_addr = 32'h0; uart_wdata = 32'hDEAD_BEEF; uart_wmask = 4'hF;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0;
        step();
        chk("load_lock_active", s_lock, 1'b1);
        chk("load_uart_gnt", s_uart_gnt, 1'b1);
        chk("load_cpu_stall", s_cpu_stall, 1'b1);
        uart_req = 0; uart_we = 0; uart_lock = 0;
        step();
        chk("load_exit_cpu_stall", s_cpu_stall, 1'b1);
        step();
        chk("normal_cpu_gnt", s_cpu_gnt, 1'b1);
        idle();
        step();
        chk("readback_rdata", s_cpu_rdata, 32'hDEAD_BEEF);

        // UART write in NORMAL: mask passes through, no response follows.
        uart_req = 1; uart_we = 1; uart_addr = 32'h8; uart_wdata = 32'h1234_5678; uart_wmask = 4'h5;
        step();
        chk("wr_mem_wmask", s_mem_wmask, 4'h5);
        idle();
        step();
        chk("wr_no_rvalid", {s_cpu_rvalid, s_uart_rvalid}, 2'b00);

        // Reset lands on the edge that accepts a UART read in LOAD.
        uart_lock = 1;
        step();
        uart_req = 1; uart_we = 0; uart_addr = 32'hC; reset = 0;
        step();
        chk("rst_read_uart_gnt", s_uart_gnt, 1'b1);
        reset = 1; uart_lock = 0; uart_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h4;
        step();
        chk("rst_read_no_rvalid", s_uart_rvalid, 1'b0);
        chk("rst_read_lock", s_lock, 1'b0);
        chk("rst_read_normal_gnt", s_cpu_gnt, 1'b1);
        idle();
        step();

        // Randomized traffic, model-checked every cycle.
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 99) < 4) uart_lock = ~uart_lock;
            cpu_req    = ($urandom_range(0, 99) < 60);
            cpu_we     = ($urandom_range(0, 99) < 40);
            cpu_addr   = 32'($urandom_range(0, 15)) << 2;
            cpu_wdata  = $urandom;
            cpu_wmask  = 4'($urandom_range(0, 15));
            uart_req   = ($urandom_range(0, 99) < 60);
            uart_we    = ($urandom_range(0, 99) < 40);
            uart_addr  = 32'($urandom_range(0, 15)) << 2;
            uart_wdata = $urandom;
            uart_wmask = 4'($urandom_range(0, 15));
            step();
        end
        reset = 1; uart_lock = 0;
        idle();
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, byte-address width of both request ports.
REQ-002 SHALL have parameter DATA_W, 32, data width; the write mask is DATA_W/8 bits wide.
REQ-003 SHALL have parameter STARVE_LIMIT, 8, the number of consecutive denied UART-loader cycles that forces a UART grant.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset: sampled on the clk rising edge, active when 0.
REQ-006 SHALL have CPU request ports: cpu_req (in, 1), cpu_we (in, 1), cpu_addr (in, ADDR_W), cpu_wdata (in, DATA_W), cpu_wmask (in, DATA_W/8).
REQ-007 SHALL have CPU response ports: cpu_gnt (out, 1), cpu_stall (out, 1), cpu_rvalid (out, 1), cpu_rdata (out, DATA_W).
REQ-008 SHALL have UART-loader ports uart_req, uart_we, uart_addr, uart_wdata, uart_wmask, uart_gnt, uart_rvalid and uart_rdata, with the same widths as the CPU ports.
REQ-009 SHALL have port uart_lock, input, 1, requesting exclusive loader ownership of the memory.
REQ-010 SHALL have port lock_active, output, 1, high while the state machine is in LOAD.
REQ-011 SHALL have memory ports mem_en, mem_we, mem_addr, mem_wdata and mem_wmask (outputs) and mem_rdata (input); the memory returns read data one cycle after mem_en with mem_we low.

Function
REQ-012 SHALL issue at most one memory access per cycle; a request is accepted in the cycle where req and gnt are both high.
REQ-013 SHALL generate gnt combinationally in the request cycle; mem_* SHALL carry the granted port's fields in that same cycle.
REQ-014 SHALL drive mem_en low when no port is granted.
REQ-015 SHALL use a state machine with states NORMAL, DRAIN and LOAD; the reset state is NORMAL.
REQ-016 In NORMAL, SHALL use fixed priority with the CPU first, unless the starvation counter equals STARVE_LIMIT, in which case the UART port wins that cycle.
REQ-017 The starvation counter SHALL increment while uart_req is high and uart_gnt is low, saturate at STARVE_LIMIT, and clear on any UART grant or when uart_req is low.
REQ-018 In NORMAL, uart_lock=1 SHALL move the state to DRAIN if a read response is outstanding, otherwise directly to LOAD.
REQ-019 DRAIN SHALL grant nobody and SHALL move to LOAD on the cycle after the outstanding rvalid.
REQ-020 LOAD SHALL grant only the UART port; uart_lock=0 SHALL return the state to NORMAL on the next edge.
REQ-021 cpu_stall SHALL equal cpu_req AND NOT cpu_gnt.
REQ-022 A registered owner tag SHALL route the response: exactly one of cpu_rvalid or uart_rvalid pulses one cycle after an accepted read, with rdata equal to mem_rdata.
REQ-023 Writes SHALL produce no rvalid.
REQ-024 Non-owner rdata SHALL be 0.
REQ-025 uart_lock falling while in DRAIN SHALL return the state to NORMAL once the drain completes.
REQ-026 uart_lock rising in the same cycle as a CPU read grant SHALL let the grant complete, then enter DRAIN.

Reset
REQ-027 With reset=0 at an edge, the arbiter SHALL enter NORMAL, clear the starvation counter and the owner/valid registers, and drive gnt, rvalid, lock_active and mem_en to 0.
REQ-028 Reset asserted mid-read SHALL suppress the pending rvalid.

Configuration
REQ-029 With macro DMEM_ARB_STARVE_GUARD_EN defined, starvation forcing (REQ-016 and REQ-017) SHALL be present.
REQ-030 Without DMEM_ARB_STARVE_GUARD_EN, the counter logic SHALL be absent and NORMAL SHALL use pure CPU-first priority.

Structure
REQ-031 Package dmem_arb_pkg SHALL hold the arb_state_e enum (NORMAL, DRAIN, LOAD), the owner_e enum (OWN_CPU, OWN_UART) and the default width constants.
REQ-032 The starvation counter SHALL be a sub-module named starve_counter; everything else stays flat.

Verification
REQ-033 Both ports issue a read to 0x10 in the same cycle -> cpu_gnt=1, uart_gnt=0, and cpu_rvalid one cycle later with the memory data.
REQ-034 CPU requests continuously while UART requests to 0x20 -> uart_gnt occurs on the 9th UART-request cycle (STARVE_LIMIT=8); with the macro undefined, no uart_gnt occurs.
REQ-035 A CPU read to 0x04 is accepted, and uart_lock rises in the same cycle -> DRAIN for one cycle, cpu_rvalid delivered, then lock_active=1.
REQ-036 In LOAD, the UART writes 0xDEADBEEF with mask 0xF to 0x0 while cpu_req=1 -> cpu_stall=1 throughout, and a later CPU read of 0x0 returns 0xDEADBEEF.
REQ-037 reset=0 is asserted during an outstanding UART read -> no uart_rvalid follows, and the state is NORMAL.
REQ-038 A UART write with uart_we=1 -> no rvalid on either port, and mem_wmask equals uart_wmask.
